// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit.
package mdu_pkg;

  localparam int MDU_WIDTH = 32;
  localparam int MDU_CNT_W = 5;

  // RV32M funct3 encodings
  localparam logic [2:0] FN_MUL    = 3'd0;
  localparam logic [2:0] FN_MULH   = 3'd1;
  localparam logic [2:0] FN_MULHSU = 3'd2;
  localparam logic [2:0] FN_MULHU  = 3'd3;
  localparam logic [2:0] FN_DIV    = 3'd4;
  localparam logic [2:0] FN_DIVU   = 3'd5;
  localparam logic [2:0] FN_REM    = 3'd6;
  localparam logic [2:0] FN_REMU   = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_SPEC = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // op_a is read as two's complement for these ops
  function automatic logic is_signed_a(input logic [2:0] fn);
    return (fn == FN_MULH) || (fn == FN_MULHSU) || (fn == FN_DIV) || (fn == FN_REM);
  endfunction

  // op_b is read as two's complement for these ops
  function automatic logic is_signed_b(input logic [2:0] fn);
    return (fn == FN_MULH) || (fn == FN_DIV) || (fn == FN_REM);
  endfunction

endpackage

// File: rtl/mdu_div_step.sv
// One restoring-division step: shift a dividend bit into the partial
// remainder and keep the trial difference when it does not borrow.
module mdu_div_step
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             dividend_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // The partial remainder is always below the divisor, so the shifted value
  // fits WIDTH+1 bits and the top bit of the difference is the borrow.
  always_comb begin
    shifted  = {rem, dividend_bit};
    diff     = shifted - {1'b0, divisor};
    q_bit    = ~diff[WIDTH];
    rem_next = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/mdu_iter.sv
// Iterative radix-2 RV32M multiply/divide unit. One iteration per cycle on
// operand magnitudes; signs are applied in a final registering cycle.
//
// Handshake: start is only sampled while busy=0 (IDLE); an accepted start
// makes busy=1 until the one-cycle done pulse, during which result/rd_out
// are valid. start while busy=1 is dropped, nothing is queued.
module mdu_iter
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH,
  parameter int CNT_W = MDU_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [4:0]       rd_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [4:0]       rd_out
);

  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_t             state, state_nx;
  logic [CNT_W-1:0]   cnt;
  logic               fin;        // all iterations done; next CALC edge registers
  logic [2:0]         fn;
  logic [4:0]         rd_q;
  logic [WIDTH-1:0]   mag_a;      // multiplicand / dividend (shifted out MSB first)
  logic [WIDTH-1:0]   mag_b;      // multiplier (shifted out LSB first) / divisor
  logic [WIDTH-1:0]   spec_val;
  logic [2*WIDTH-1:0] acc;        // product, or remainder:quotient
  logic               neg_q;      // negate product / quotient
  logic               neg_r;      // negate remainder

  logic               sgn_a, sgn_b;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic               special;
  logic [WIDTH-1:0]   special_val;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH-1:0]   div_rem_nx;
  logic               div_q_bit;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   quo_s, rem_s, fin_val;

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE);

  // Operand decode at accept: magnitudes, sign flags and divide special cases
  always_comb begin
    sgn_a       = is_signed_a(funct3) & op_a[WIDTH-1];
    sgn_b       = is_signed_b(funct3) & op_b[WIDTH-1];
    abs_a       = sgn_a ? -op_a : op_a;
    abs_b       = sgn_b ? -op_b : op_b;
    special     = 1'b0;
    special_val = '0;
    if (funct3[2]) begin
      if (op_b == '0) begin
        special     = 1'b1;
        special_val = funct3[1] ? op_a : '1;
      end else if (is_signed_b(funct3) && op_a == MIN_NEG && op_b == '1) begin
        special     = 1'b1;
        special_val = funct3[1] ? '0 : MIN_NEG;
      end
    end
  end

  // Shift-add multiply step: add the multiplicand into the high half when
  // the current multiplier bit is set, then shift the whole product right.
  always_comb begin
    mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (mag_b[0] ? mag_a : '0)};
  end

  mdu_div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem          (acc[2*WIDTH-1:WIDTH]),
    .dividend_bit (mag_a[WIDTH-1]),
    .divisor      (mag_b),
    .rem_next     (div_rem_nx),
    .q_bit        (div_q_bit)
  );

  // Sign correction and word selection for the registering edge
  always_comb begin
    prod_s = neg_q ? -acc : acc;
    quo_s  = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_s  = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    case (fn)
      FN_MUL:                       fin_val = prod_s[WIDTH-1:0];
      FN_MULH, FN_MULHSU, FN_MULHU: fin_val = prod_s[2*WIDTH-1:WIDTH];
      FN_DIV, FN_DIVU:              fin_val = quo_s;
      default:                      fin_val = rem_s;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (start) state_nx = special ? ST_SPEC : ST_CALC;
      ST_CALC: if (fin)   state_nx = ST_DONE;
      ST_SPEC:            state_nx = ST_DONE;
      ST_DONE:            state_nx = ST_IDLE;
      default:            state_nx = ST_IDLE;
    endcase
  end

  // Datapath: latch at accept, iterate in CALC, register outputs at the end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      fin      <= 1'b0;
      fn       <= '0;
      rd_q     <= '0;
      mag_a    <= '0;
      mag_b    <= '0;
      spec_val <= '0;
      acc      <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      result   <= '0;
      rd_out   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            fn       <= funct3;
            rd_q     <= rd_in;
            mag_a    <= abs_a;
            mag_b    <= abs_b;
            neg_q    <= sgn_a ^ sgn_b;
            neg_r    <= sgn_a;
            spec_val <= special_val;
            acc      <= '0;
            cnt      <= '0;
            fin      <= 1'b0;
          end
        end
        ST_CALC: begin
          if (!fin) begin
            if (fn[2]) begin
              acc   <= {div_rem_nx, acc[WIDTH-2:0], div_q_bit};
              mag_a <= mag_a << 1;
            end else begin
              acc   <= {mul_sum, acc[WIDTH-1:1]};
              mag_b <= mag_b >> 1;
            end
            cnt <= cnt + CNT_W'(1);
            if (cnt == '1) fin <= 1'b1;
          end else begin
            result <= fin_val;
            rd_out <= rd_q;
          end
        end
        ST_SPEC: begin
          result <= spec_val;
          rd_out <= rd_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter: directed corner cases plus randomized
// operations scored against a plain-arithmetic reference model.
module tb_mdu_iter;

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [4:0]  rd_in;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [4:0]  rd_out;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [31:0] exp_q[$];
  logic [4:0]  rd_q[$];
  int          cyc_q[$];

  mdu_iter dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .funct3 (funct3),
    .op_a   (op_a),
    .op_b   (op_b),
    .rd_in  (rd_in),
    .busy   (busy),
    .done   (done),
    .result (result),
    .rd_out (rd_out)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: RV32M semantics using full-width arithmetic
  function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a,
                                            input logic [31:0] b);
    logic signed [31:0] sa, sb;
    logic signed [63:0] xa, xb;
    logic [63:0]        p;
    logic [31:0]        r;
    sa = a;
    sb = b;
    r  = '0;
    case (f)
      3'd0: r = a * b;
      3'd1: begin xa = sa; xb = sb; p = xa * xb; r = p[63:32]; end
      3'd2: begin xa = sa; xb = {32'd0, b}; p = xa * xb; r = p[63:32]; end
      3'd3: begin p = {32'd0, a} * {32'd0, b}; r = p[63:32]; end
      3'd4: begin
        if (b == 0) r = 32'hFFFF_FFFF;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h8000_0000;
        else r = sa / sb;
      end
      3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) r = a;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'd0;
        else r = sa % sb;
      end
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  function automatic bit is_special(input logic [2:0] f, input logic [31:0] a,
                                    input logic [31:0] b);
    if (f < 3'd4) return 1'b0;
    if (b == 0) return 1'b1;
    return (f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
  endfunction

  // ---------------- driver ----------------
  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd);
    int t = 0;
    @(negedge clk);
    while (busy && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (busy) check("issue_wait_timeout", 64'(busy), 64'd0);
    start  = 1'b1;
    funct3 = f;
    op_a   = a;
    op_b   = b;
    rd_in  = rd;
    exp_q.push_back(ref_model(f, a, b));
    rd_q.push_back(rd);
    cyc_q.push_back(cyc + 1 + (is_special(f, a, b) ? 1 : 33));
    @(negedge clk);
    start  = 1'b0;
    op_a   = $urandom;
    op_b   = $urandom;
    rd_in  = 5'($urandom_range(0, 31));
    funct3 = 3'($urandom_range(0, 7));
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((busy || exp_q.size() != 0) && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) check("wait_idle_timeout", 64'(exp_q.size()), 64'd0);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 9))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      5:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (done) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual=done required=no_done (cycle %0d, result=%0h)",
                 cyc, result);
      end else begin
        logic [31:0] e_res;
        logic [4:0]  e_rd;
        int          e_cyc;
        e_res = exp_q.pop_front();
        e_rd  = rd_q.pop_front();
        e_cyc = cyc_q.pop_front();
        check("result", 64'(result), 64'(e_res));
        check("rd_out", 64'(rd_out), 64'(e_rd));
        check("done_cycle", 64'(cyc), 64'(e_cyc));
        check("busy_at_done", 64'(busy), 64'd1);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int n;
    rst    = 1'b1;
    start  = 1'b0;
    funct3 = 3'd0;
    op_a   = '0;
    op_b   = '0;
    rd_in  = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_result", 64'(result), 64'd0);
    check("reset_rd_out", 64'(rd_out), 64'd0);
    rst = 1'b0;

    // MUL 7 x -3 with busy-length measurement
    issue(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd12);
    n = 0;
    while (busy && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("mul_busy_cycles", 64'(n), 64'd34);
    check("mul_7x-3_value", 64'(result), 64'h0000_0000_FFFF_FFEB);

    // high words of 0x80000000 x 0xFFFFFFFF
    issue(3'd1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd1);
    issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 5'd2);
    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 5'd3);

    // signed / unsigned divide
    issue(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd4);
    issue(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd5);
    issue(3'd5, 32'd100, 32'd7, 5'd6);
    issue(3'd7, 32'd100, 32'd7, 5'd0);

    // special cases, back-to-back
    issue(3'd4, 32'd5, 32'd0, 5'd7);
    issue(3'd6, 32'd5, 32'd0, 5'd8);
    issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9);
    issue(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10);
    issue(3'd5, 32'd9, 32'd0, 5'd11);
    issue(3'd7, 32'd9, 32'd0, 5'd13);
    wait_idle();

    // start pulses during a running DIVU are ignored
    issue(3'd5, 32'd1000, 32'd7, 5'd9);
    repeat (4) @(negedge clk);
    start = 1'b1; funct3 = 3'd0; op_a = 32'd3; op_b = 32'd3; rd_in = 5'd30;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    start = 1'b1; funct3 = 3'd4; op_a = 32'd1; op_b = 32'd0; rd_in = 5'd31;
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    repeat (5) @(negedge clk);
    check("ignored_start_result_held", 64'(result), 64'd142);
    check("ignored_start_rd_held", 64'(rd_out), 64'd9);

    // reset in the middle of a MUL aborts it
    issue(3'd0, 32'h1234_5678, 32'h9ABC_DEF1, 5'd3);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    rd_q.delete();
    cyc_q.delete();
    @(negedge clk);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_result", 64'(result), 64'd0);
    check("abort_rd_out", 64'(rd_out), 64'd0);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    issue(3'd0, 32'd123, 32'd456, 5'd14);
    wait_idle();

    // randomized operations
    for (int i = 0; i < 48; i++) begin
      logic [2:0]  f;
      logic [31:0] a, b;
      f = 3'($urandom_range(0, 7));
      a = pick_operand();
      b = pick_operand();
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
      issue(f, a, b, 5'($urandom_range(0, 31)));
    end
    wait_idle();
    repeat (5) @(negedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mdu_iter.md
Name: mdu_iter

Overview:
- Iterative RV32M multiply/divide unit in the execute stage of the single-cycle CPU.
- Consumes the two register-file read operands and returns a 32-bit result plus destination index for the register-file write port.
- The core stalls the PC while `busy`=1. It drives `regwrite` from `done`.
- Radix-2, one iteration per cycle, fixed latency except divide special cases.

Parameters:
- WIDTH, 32, operand/result width (only 32 supported and verified)
- CNT_W, 5, iteration counter width (log2 WIDTH)

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous active-high reset
- start  in  1  request; sampled only in IDLE
- funct3  in  3  RV32M op: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- op_a  in  WIDTH  rs1 value (dividend / multiplicand)
- op_b  in  WIDTH  rs2 value (divisor / multiplier)
- rd_in  in  5  destination register index
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse, result/rd_out valid
- result  out  WIDTH  registered result, held until next accepted start
- rd_out  out  5  registered copy of rd_in for the write port

Behaviour:
- Reset: state=IDLE; busy=0, done=0, result=0, rd_out=0; counter and internal regs cleared.
- Reset has priority over everything, including mid-operation: any op is aborted and no done is produced.
- States:
  - IDLE -> CALC: on start=1.
  - IDLE -> SPEC: on start=1 with a divide special case.
  - CALC -> DONE: after the 32nd iteration.
  - SPEC -> DONE.
  - DONE -> IDLE: unconditionally.
- Accept edge k (start=1 in IDLE):
  - Latch funct3 and rd_in.
  - Latch operand magnitudes: abs value for signed-interpreted operands, where MULH signs both, MULHSU signs op_a only, DIV/REM sign both.
  - Latch the result sign flags.
  - Clear the 64-bit accumulator and the counter.
- start while busy=1 (CALC/SPEC/DONE) is ignored; no queueing. Operand inputs are don't-care after edge k.
- Multiply (CALC), edges k+1..k+32:
  - Shift-add one multiplier bit per edge, LSB first, into the 64-bit product.
  - At edge k+33: negate if the sign flag is set; register the low word (MUL) or high word (MULH/MULHSU/MULHU) into result; enter DONE.
- Divide (CALC), edges k+1..k+32:
  - Restoring division: shift remainder:quotient left, trial-subtract the divisor magnitude, set the quotient bit if no borrow.
  - At edge k+33: apply signs; quotient sign = sign(a) XOR sign(b); remainder sign = sign(a). Register the quotient (DIV/DIVU) or remainder (REM/REMU); enter DONE.
- Divide special cases, decided at accept, go via SPEC; result registered at edge k+1:
  - b=0: DIV/DIVU -> 0xFFFFFFFF; REM/REMU -> op_a.
  - Signed overflow (a=0x80000000, b=0xFFFFFFFF, DIV/REM): DIV -> 0x80000000; REM -> 0.
  - Multiplies never take SPEC.
- Latency:
  - Normal ops: done=1 in the cycle after edge k+33, i.e. exactly 33 edges after accept.
  - Special cases: done=1 in the cycle after edge k+1.
  - busy=1 from after edge k through the done cycle inclusive.
- done is high for exactly one cycle.
- result and rd_out change only at the registering edge and hold afterwards.
- rd_in=0 is processed normally; suppressing the x0 write is the register file's job.
- Back-to-back: start may be high in the cycle after done (state is IDLE again) and is accepted. Minimum issue interval is 35 cycles normal, 3 cycles special.
- Arithmetic is modulo 2^WIDTH. abs(0x80000000) = 0x80000000 read as unsigned, and the algorithm must be correct for it.

Decomposition:
- Shared package `mdu_pkg`:
  - funct3 localparams (FN_MUL..FN_REMU)
  - state encoding (IDLE, CALC, SPEC, DONE)
  - WIDTH default
- One natural sub-module `mdu_div_step`: combinational single restoring-division step.
  - Inputs: remainder, dividend bit, divisor.
  - Outputs: next remainder, quotient bit.
  - Instantiated once in `mdu_iter`; the multiply step stays inline.

Test Plan:
- MUL 7 x -3 (op_a=7, op_b=0xFFFFFFFD): done exactly 33 edges after accept, result=0xFFFFFFEB, busy high 34 cycles, rd_out=rd_in.
- High words with a=0x80000000, b=0xFFFFFFFF: MULH -> 0x00000000; MULHU -> 0x7FFFFFFF; MULHSU -> 0x80000000.
- DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- Special cases:
  - DIV 5/0 -> 0xFFFFFFFF and REM 5/0 -> 5, done 1 edge after accept.
  - DIV 0x80000000/-1 -> 0x80000000 and REM -> 0.
- start pulsed again at cycles k+5 and k+20 of a running DIVU -> ignored, exactly one done, result unchanged.
- rst asserted at k+10 of a MUL -> next cycle busy=0, done=0, result=0; no done ever follows. A new start then completes normally with the correct value.
